// File: rtl/if_stage.sv
// Instruction fetch stage: one outstanding doubleword fetch at a time, hands a
// single 32-bit instruction to decode and follows redirects from execute.
module if_stage #(
  parameter logic [63:0] PC_RESET = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [63:0] if_addr,
  output logic [1:0]  if_size,
  input  logic [63:0] if_data_read,
  input  logic        jump_ena,
  input  logic [63:0] jump_addr,
  input  logic        id_ready,
  output logic [63:0] pc,
  output logic [31:0] inst,
  output logic        inst_valid,
  output logic [1:0]  state_dbg
);
  // Handshakes: the memory request (if_valid/if_addr) stays stable until a
  // cycle with if_ready=1 completes it; decode consumes inst on inst_valid &&
  // id_ready. A redirect (jump_ena) always takes priority over acceptance.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic        jump_pend_q, jump_pend_d;
  logic [63:0] jump_tgt_q, jump_tgt_d;
  logic        if_valid_q, if_valid_d;
  logic        inst_valid_q, inst_valid_d;
  logic [63:0] jump_aligned;

  assign jump_aligned = jump_addr & ~64'h3;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    inst_d      = inst_q;
    jump_pend_d = jump_pend_q;
    jump_tgt_d  = jump_tgt_q;
    case (state_q)
      IDLE: begin
        if (jump_ena) pc_d = jump_aligned;
        state_d = FETCH;
      end
      FETCH: begin
        if (if_ready) begin
          if (jump_pend_q || jump_ena) begin
            // A redirect seen during the request makes the returned data stale.
            pc_d        = jump_ena ? jump_aligned : jump_tgt_q;
            jump_pend_d = 1'b0;
            state_d     = IDLE;
          end else begin
            inst_d  = pc_q[2] ? if_data_read[63:32] : if_data_read[31:0];
            state_d = HOLD;
          end
        end else if (jump_ena) begin
          jump_pend_d = 1'b1;
          jump_tgt_d  = jump_aligned;
        end
      end
      HOLD: begin
        if (jump_ena) begin
          pc_d    = jump_aligned;
          state_d = IDLE;
        end else if (id_ready) begin
          pc_d    = pc_q + 64'd4;
          state_d = FETCH;
        end
      end
      default: state_d = IDLE;
    endcase
    if_valid_d   = (state_d == FETCH);
    inst_valid_d = (state_d == HOLD);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      pc_q         <= PC_RESET;
      inst_q       <= 32'h0;
      jump_pend_q  <= 1'b0;
      jump_tgt_q   <= 64'h0;
      if_valid_q   <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      jump_pend_q  <= jump_pend_d;
      jump_tgt_q   <= jump_tgt_d;
      if_valid_q   <= if_valid_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign if_valid   = if_valid_q;
  assign if_addr    = pc_q & ~64'h7;
  assign if_size    = 2'b11;
  assign pc         = pc_q;
  assign inst       = inst_q;
  assign inst_valid = inst_valid_q;
  assign state_dbg  = state_q;
endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios followed by random memory latency,
// decode stalls and redirects against an instruction-stream model.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_valid;
  logic        if_ready;
  logic [63:0] if_addr;
  logic [1:0]  if_size;
  logic [63:0] if_data_read;
  logic        jump_ena;
  logic [63:0] jump_addr;
  logic        id_ready;
  logic [63:0] pc;
  logic [31:0] inst;
  logic        inst_valid;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_bad = 0;

  if_stage dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_ready(if_ready),
    .if_addr(if_addr), .if_size(if_size), .if_data_read(if_data_read),
    .jump_ena(jump_ena), .jump_addr(jump_addr), .id_ready(id_ready),
    .pc(pc), .inst(inst), .inst_valid(inst_valid), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Memory image: each 4-byte word holds a value derived from its address.
  function automatic logic [31:0] word_at(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [63:0] mem_dw(input logic [63:0] a);
    logic [63:0] base;
    base = a & ~64'h7;
    return {word_at(base + 64'd4), word_at(base)};
  endfunction

  initial begin
    logic [63:0] exp_pc;
    logic [63:0] prev_addr;
    logic        prev_req;
    int          n_deliv;

    rst = 1'b1; if_ready = 1'b0; if_data_read = 64'h0;
    jump_ena = 1'b0; jump_addr = 64'h0; id_ready = 1'b0;
    step();
    step();
    chk("rst_if_valid", {63'h0, if_valid}, 64'h0);
    chk("rst_inst_valid", {63'h0, inst_valid}, 64'h0);
    chk("rst_pc", pc, 64'h8000_0000);
    chk("rst_inst", {32'h0, inst}, 64'h0);
    chk("if_size", {62'h0, if_size}, 64'h3);

    // Basic fetch of two instructions from one doubleword
    rst = 1'b0;
    step();
    chk("first_if_valid", {63'h0, if_valid}, 64'h1);
    chk("first_if_addr", if_addr, 64'h8000_0000);
    if_ready = 1'b1; if_data_read = 64'h00100093_00000013; id_ready = 1'b1;
    step();
    chk("i0_valid", {63'h0, inst_valid}, 64'h1);
    chk("i0_inst", {32'h0, inst}, 64'h0000_0013);
    chk("i0_pc", pc, 64'h8000_0000);
    chk("i0_no_req", {63'h0, if_valid}, 64'h0);
    if_ready = 1'b0;
    step();
    chk("i1_req_valid", {63'h0, if_valid}, 64'h1);
    chk("i1_inst_valid_low", {63'h0, inst_valid}, 64'h0);
    chk("i1_if_addr", if_addr, 64'h8000_0000);
    if_ready = 1'b1;
    step();
    chk("i1_inst", {32'h0, inst}, 64'h0010_0093);
    chk("i1_pc", pc, 64'h8000_0004);
    if_ready = 1'b0;
    step();
    chk("i2_if_addr", if_addr, 64'h8000_0008);

    // Slow memory: request held for 7 cycles
    for (int i = 0; i < 7; i++) begin
      step();
      chk("slow_if_valid", {63'h0, if_valid}, 64'h1);
      chk("slow_if_addr", if_addr, 64'h8000_0008);
      chk("slow_inst_valid", {63'h0, inst_valid}, 64'h0);
    end
    if_ready = 1'b1; if_data_read = 64'h11111111_22222222; id_ready = 1'b0;
    step();
    if_ready = 1'b0;

    // Decode stall for 5 cycles
    for (int i = 0; i < 5; i++) begin
      chk("stall_inst", {32'h0, inst}, 64'h2222_2222);
      chk("stall_pc", pc, 64'h8000_0008);
      chk("stall_inst_valid", {63'h0, inst_valid}, 64'h1);
      chk("stall_if_valid", {63'h0, if_valid}, 64'h0);
      step();
    end
    id_ready = 1'b1;
    step();
    chk("release_pc", pc, 64'h8000_000C);
    chk("release_inst_valid", {63'h0, inst_valid}, 64'h0);

    // Redirect during an outstanding fetch
    jump_ena = 1'b1; jump_addr = 64'h8000_0103;
    step();
    jump_ena = 1'b0;
    chk("jp_if_valid", {63'h0, if_valid}, 64'h1);
    chk("jp_if_addr", if_addr, 64'h8000_0008);
    if_ready = 1'b1; if_data_read = 64'hBADB_ADBA_DBAD_BADB;
    step();
    if_ready = 1'b0;
    chk("jp_discard_inst_valid", {63'h0, inst_valid}, 64'h0);
    chk("jp_idle_if_valid", {63'h0, if_valid}, 64'h0);
    chk("jp_pc", pc, 64'h8000_0100);
    step();
    chk("jp_new_if_addr", if_addr, 64'h8000_0100);
    chk("jp_new_inst_valid", {63'h0, inst_valid}, 64'h0);
    if_ready = 1'b1; if_data_read = 64'h33333333_44444444; id_ready = 1'b0;
    step();
    if_ready = 1'b0;
    chk("jp_tgt_inst", {32'h0, inst}, 64'h4444_4444);
    chk("jp_tgt_pc", pc, 64'h8000_0100);

    // Redirect and decode-accept together in HOLD
    jump_ena = 1'b1; jump_addr = 64'h8000_1000; id_ready = 1'b1;
    step();
    jump_ena = 1'b0;
    chk("jh_pc", pc, 64'h8000_1000);
    chk("jh_idle_if_valid", {63'h0, if_valid}, 64'h0);
    chk("jh_inst_valid", {63'h0, inst_valid}, 64'h0);
    step();
    chk("jh_if_addr", if_addr, 64'h8000_1000);
    chk("jh_if_valid", {63'h0, if_valid}, 64'h1);

    // Reset mid-fetch with a late response
    rst = 1'b1;
    step();
    rst = 1'b0; if_ready = 1'b1; if_data_read = 64'hDEAD_DEAD_DEAD_DEAD;
    step();
    if_ready = 1'b0;
    chk("rr_if_addr", if_addr, 64'h8000_0000);
    chk("rr_if_valid", {63'h0, if_valid}, 64'h1);
    chk("rr_inst_valid", {63'h0, inst_valid}, 64'h0);
    chk("rr_pc", pc, 64'h8000_0000);

    // Random phase: model tracks the address of the next instruction due
    exp_pc = 64'h8000_0000;
    prev_req = 1'b0;
    prev_addr = 64'h0;
    n_deliv = 0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (prev_req) begin
        chk("rnd_req_held", {63'h0, if_valid}, 64'h1);
        chk("rnd_req_addr", if_addr, prev_addr);
      end
      if (inst_valid) begin
        chk("rnd_pc", pc, exp_pc);
        chk("rnd_inst", {32'h0, inst}, {32'h0, word_at(exp_pc)});
      end
      chk("rnd_no_prefetch", {63'h0, if_valid & inst_valid}, 64'h0);

      if (if_valid) begin
        if_ready = ($urandom_range(0, 2) == 0);
        if_data_read = mem_dw(if_addr);
      end else begin
        if_ready = ($urandom_range(0, 7) == 0);
        if_data_read = {$urandom, $urandom};
      end
      id_ready = ($urandom_range(0, 3) != 0);
      jump_ena = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 7) == 0)
        jump_addr = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      else
        jump_addr = 64'h8000_0000 + 64'($urandom_range(0, 4095));

      if (jump_ena) exp_pc = jump_addr & ~64'h3;
      else if (inst_valid && id_ready) begin
        exp_pc = exp_pc + 64'd4;
        n_deliv++;
      end
      prev_req = if_valid && !if_ready;
      prev_addr = if_addr;
      step();
    end
    jump_ena = 1'b0; if_ready = 1'b0;
    chk("rnd_progress", {63'h0, n_deliv > 50}, 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
